// File: rtl/xkrc_pkg.sv
// xkrc_pkg: shared constants, FSM states and word-slice helper for the decrypt key schedule
package xkrc_pkg;
  localparam int ROUNDS_D = 16;
  localparam int WORDS = 4;
  localparam int ROT_K = 5;
  localparam int ROT_RC = 16;
  typedef enum logic [1:0] {IDLE, WIND, RUN, DRAIN} state_t;
  function automatic logic [0:15] word_of(input logic [0:63] v, input logic [1:0] w);
    return v[{w, 4'b0000} +: 16];
  endfunction
endpackage

// File: rtl/xkrc_dec_sched_if.sv
// xkrc_dec_sched_if: key material, state-word stream and status signals of the decrypt XOR engine
interface xkrc_dec_sched_if #(parameter int ROUNDS = xkrc_pkg::ROUNDS_D);
  logic start;
  logic [0:63] k0_in, k1_in, rc_in;
  logic [0:ROUNDS-1] sel_k0k1;
  logic [0:15] x_word, y_word;
  logic x_valid, x_ready, y_valid, y_ready;
  logic busy, done;
  modport master (output start, k0_in, k1_in, rc_in, sel_k0k1, x_word, x_valid, y_ready,
                  input x_ready, y_word, y_valid, busy, done);
  modport slave (input start, k0_in, k1_in, rc_in, sel_k0k1, x_word, x_valid, y_ready,
                 output x_ready, y_word, y_valid, busy, done);
endinterface

// File: rtl/xkrc_rot_reg.sv
// xkrc_rot_reg: 64-bit key/constant register that loads, rotates left or rotates right by ROT bits
module xkrc_rot_reg #(parameter int ROT = 5) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [0:63] d,
  input  logic        rot_fwd,
  input  logic        rot_rev,
  output logic [0:63] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (load) q <= d;
    else if (rot_fwd) q <= {q[ROT:63], q[0:ROT-1]};
    else if (rot_rev) q <= {q[64-ROT:63], q[0:63-ROT]};
endmodule

// File: rtl/xkrc_dec_sched.sv
// xkrc_dec_sched: winds the encrypt key/RC schedule to the last round, then XORs
// state words with it while unwinding round by round back to round 0
module xkrc_dec_sched import xkrc_pkg::*; #(parameter int ROUNDS = ROUNDS_D) (
  input logic clk,
  input logic rst_n,
  xkrc_dec_sched_if.slave io
);
  localparam int CW = ROUNDS > 1 ? $clog2(ROUNDS) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [1:0] w;
  logic [0:ROUNDS-1] sel;
  logic [0:63] k0, k1, rc;
  logic [0:15] y_word;
  logic y_valid, done, load, fwd, rdy, take, last;
  assign rdy = state == RUN && (!y_valid || io.y_ready);
  assign take = io.x_valid && rdy;
  assign last = take && w == 2'(WORDS - 1);
  assign io.x_ready = rdy;
  assign io.y_word = y_word;
  assign io.y_valid = y_valid;
  assign io.busy = state != IDLE;
  assign io.done = done;
  xkrc_rot_reg #(.ROT(ROT_K)) u_k0 (.clk, .rst_n, .load, .d(io.k0_in), .rot_fwd(fwd), .rot_rev(last), .q(k0));
  xkrc_rot_reg #(.ROT(ROT_K)) u_k1 (.clk, .rst_n, .load, .d(io.k1_in), .rot_fwd(fwd), .rot_rev(last), .q(k1));
  xkrc_rot_reg #(.ROT(ROT_RC)) u_rc (.clk, .rst_n, .load, .d(io.rc_in), .rot_fwd(fwd), .rot_rev(last), .q(rc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    load = 1'b0;
    fwd = 1'b0;
    case (state)
      IDLE: begin
        load = io.start;
        if (io.start) nxt = ROUNDS > 1 ? WIND : RUN;
      end
      WIND: begin
        fwd = 1'b1;
        if (cnt == CW'(1)) nxt = RUN;
      end
      RUN: if (last && cnt == '0) nxt = DRAIN;
      default: if (y_valid && io.y_ready) nxt = IDLE;
    endcase
  end
  // sel shifts toward its last bit each round so sel[ROUNDS-1] always names the current round
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      w <= '0;
      sel <= '0;
      y_word <= '0;
      y_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == DRAIN && y_valid && io.y_ready;
      if (load) begin
        cnt <= CW'(ROUNDS - 1);
        w <= '0;
        sel <= io.sel_k0k1;
      end else if (fwd) cnt <= cnt == CW'(1) ? CW'(ROUNDS - 1) : cnt - 1'b1;
      else if (take) begin
        w <= w + 1'b1;
        if (last) begin
          cnt <= cnt - 1'b1;
          sel <= sel >> 1;
        end
      end
      if (take) begin
        y_word <= io.x_word ^ word_of(sel[ROUNDS-1] ? k1 : k0, w) ^ word_of(rc, w);
        y_valid <= 1'b1;
      end else if (io.y_ready) y_valid <= 1'b0;
    end
endmodule

// File: tb/tb_xkrc_dec_sched.sv
// tb_xkrc_dec_sched: directed checks of the decrypt XOR engine at ROUNDS=1, 2 and 16
module tb_xkrc_dec_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0, cyc = 0, dsel = 0;
  logic start = 1'b0, x_valid = 1'b0, y_ready = 1'b1;
  logic [63:0] k0 = '0, k1 = '0, rc = '0, ka, kb, kc;
  logic [0:15] selv = '0, sa;
  logic [15:0] x_word = '0, y_word, held;
  logic x_ready, y_valid, busy, done, stall = 1'b0;
  logic [15:0] xs [64];
  logic [15:0] got [$];
  int ndone = 0, last_y = -1, done_cyc = -1, first_yv = -1, fx = -1;

  xkrc_dec_sched_if #(.ROUNDS(1)) if1 ();
  xkrc_dec_sched_if #(.ROUNDS(2)) if2 ();
  xkrc_dec_sched_if #(.ROUNDS(16)) if16 ();
  xkrc_dec_sched #(.ROUNDS(1)) u1 (.clk(clk), .rst_n(rst_n), .io(if1.slave));
  xkrc_dec_sched #(.ROUNDS(2)) u2 (.clk(clk), .rst_n(rst_n), .io(if2.slave));
  xkrc_dec_sched #(.ROUNDS(16)) u16 (.clk(clk), .rst_n(rst_n), .io(if16.slave));

  assign if1.start = start && dsel == 0;
  assign if2.start = start && dsel == 1;
  assign if16.start = start && dsel == 2;
  assign if1.x_valid = x_valid && dsel == 0;
  assign if2.x_valid = x_valid && dsel == 1;
  assign if16.x_valid = x_valid && dsel == 2;
  assign {if1.k0_in, if1.k1_in, if1.rc_in, if1.x_word, if1.y_ready} = {k0, k1, rc, x_word, y_ready};
  assign {if2.k0_in, if2.k1_in, if2.rc_in, if2.x_word, if2.y_ready} = {k0, k1, rc, x_word, y_ready};
  assign {if16.k0_in, if16.k1_in, if16.rc_in, if16.x_word, if16.y_ready} = {k0, k1, rc, x_word, y_ready};
  assign if1.sel_k0k1 = selv[0:0];
  assign if2.sel_k0k1 = selv[0:1];
  assign if16.sel_k0k1 = selv;
  assign x_ready = dsel == 0 ? if1.x_ready : dsel == 1 ? if2.x_ready : if16.x_ready;
  assign y_valid = dsel == 0 ? if1.y_valid : dsel == 1 ? if2.y_valid : if16.y_valid;
  assign y_word = dsel == 0 ? if1.y_word : dsel == 1 ? if2.y_word : if16.y_word;
  assign busy = dsel == 0 ? if1.busy : dsel == 1 ? if2.busy : if16.busy;
  assign done = dsel == 0 ? if1.done : dsel == 1 ? if2.done : if16.done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    int s = n % 64;
    return s == 0 ? v : (v << s) | (v >> (64 - s));
  endfunction

  // reference: encrypt round key r is the master key rotated left 5*r, RC rotated left 16*r
  function automatic logic [15:0] expw(input int rounds, input int m, input logic [15:0] x);
    int r = rounds - 1 - m / 4, w = m % 4;
    logic [63:0] k = rotl(sa[r] ? kb : ka, 5 * r), c = rotl(kc, 16 * r);
    return x ^ k[63-16*w -: 16] ^ c[63-16*w -: 16];
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (stall) chk("hold", {y_valid, y_word}, {1'b1, held});
    stall = y_valid && !y_ready;
    held = y_word;
    if (y_valid && y_ready) begin got.push_back(y_word); last_y = cyc; end
    if (y_valid && first_yv < 0) first_yv = cyc;
    if (done) begin ndone++; done_cyc = cyc; end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [63:0] a, b, c, input logic [0:15] s);
    ka = a; kb = b; kc = c; sa = s;
    k0 = a; k1 = b; rc = c; selv = s;
    got.delete(); first_yv = -1; fx = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    k0 = ~a; k1 = ~b; rc = ~c; selv = ~s;
  endtask

  task automatic drive(input int n, input bit rnd, output int wind);
    int i = 0, c = 0;
    wind = 0;
    while (i < n && c < 3000) begin
      x_valid = 1'b1;
      x_word = xs[i];
      y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = c == 3 || i == n / 2;
      @(negedge clk);
      if (x_ready) begin
        if (i == 0) fx = cyc;
        i++;
      end else if (i == 0) wind++;
      tick();
      c++;
    end
    x_valid = 1'b0;
    start = 1'b0;
    chk("accepted", i, n);
  endtask

  task automatic run(input int n, input bit rnd, input int exp_wind);
    int wind, c = 0, nd = ndone;
    drive(n, rnd, wind);
    chk("wind", wind, exp_wind);
    while (ndone == nd && c < 500) begin
      y_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      c++;
    end
    y_ready = 1'b1;
    chk("done", ndone, nd + 1);
    chk("idle_busy", {busy, x_ready}, 0);
    chk("count", got.size(), n);
    chk("latency", first_yv, fx + 1);
    chk("done_gap", done_cyc, last_y + 1);
    repeat (3) tick();
    chk("one_done", ndone, nd + 1);
  endtask

  initial begin
    int wind, nd;
    tick();
    chk("rst", {busy, done, x_ready, y_valid, y_word}, 0);
    rst_n = 1'b1;
    tick();
    x_valid = 1'b1;
    x_word = 16'h0005;
    @(negedge clk);
    chk("idle_xready", x_ready, 0);
    tick();
    tick();
    chk("idle_noy", {y_valid, 16'(got.size())}, 0);
    x_valid = 1'b0;

    for (int i = 0; i < 64; i++) xs[i] = 16'h0005;
    start_run(64'h0001_0001_0001_0001, 64'h0, 64'h0003_0003_0003_0003, 16'h0);
    run(4, 1'b0, 0);
    for (int m = 0; m < 4; m++) chk("r1_k0", got[m], 16'h0007);

    start_run(64'h0, 64'h0021_0021_0021_0021, 64'h0003_0003_0003_0003, 16'h8000);
    run(4, 1'b0, 0);
    for (int m = 0; m < 4; m++) chk("r1_k1", got[m], 16'h0027);

    dsel = 1;
    start_run(64'h0001_0001_0001_0001, 64'h0, 64'h0003_0003_0003_0003, 16'h0);
    run(8, 1'b0, 1);
    for (int m = 0; m < 8; m++) chk("r2", got[m], m < 4 ? 16'h0026 : 16'h0007);

    dsel = 2;
    for (int i = 0; i < 64; i++) xs[i] = 16'($urandom);
    nd = ndone;
    start_run({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
    drive(26, 1'b0, wind);
    rst_n = 1'b0;
    #1;
    chk("abort_out", {busy, done, x_ready, y_valid, y_word}, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("abort_nodone", ndone, nd);

    start_run({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 16'($urandom));
    run(64, 1'b1, 15);
    for (int m = 0; m < 64 && m < got.size(); m++) chk("r16", got[m], expw(16, m, xs[m]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
